hbridge_chopper: RTL and testbench

Fixed-off-time current chopper and H-bridge switch sequencer for one motor coil. It compares measured coil current against a target current and produces the four bridge switch enables (s_l1, s_h1, s_l2, s_h2). Dead-time is inserted before every switch turn-on. It sits directly upstream of the coil/bridge and consumes the coil's 13-bit current measurement as feedback.

---
 rtl/hbridge_pkg.sv | 26 ++
 rtl/hbridge_chopper.sv | 103 ++++++++++
 tb/tb_hbridge_chopper.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared states, polarity constants and switch patterns for the H-bridge chopper
package hbridge_pkg;

  typedef enum logic [1:0] {
    OFF,
    DEAD,
    DRIVE,
    DECAY
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Switch patterns, bit order {h1, l1, h2, l2}
  localparam logic [3:0] PAT_OFF   = 4'b0000;
  localparam logic [3:0] PAT_FWD   = 4'b1001;
  localparam logic [3:0] PAT_REV   = 4'b0110;
  localparam logic [3:0] PAT_BRAKE = 4'b0101;

  // Bridge pattern for a state; only DRIVE depends on polarity
  function automatic logic [3:0] switch_pattern(input state_t s, input logic d);
    return s == DRIVE ? (d == DIR_REV ? PAT_REV : PAT_FWD) :
           s == DECAY ? PAT_BRAKE : PAT_OFF;
  endfunction

endpackage

// File: rtl/hbridge_chopper.sv
// hbridge_chopper: fixed-off-time current chopper with dead-time protected H-bridge sequencing
module hbridge_chopper
  import hbridge_pkg::*;
#(
  parameter int CURRENT_W = 13,
  parameter int DEADTIME  = 4,
  parameter int BLANK     = 8,
  parameter int TOFF      = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 dir,
  input  logic [CURRENT_W-1:0] target,
  input  logic [CURRENT_W-1:0] current,
  output logic                 s_l1,
  output logic                 s_h1,
  output logic                 s_l2,
  output logic                 s_h2,
  output logic                 drive_active,
  output logic                 decay_active
);

  localparam int MAX_A = DEADTIME > BLANK ? DEADTIME : BLANK;
  localparam int MAX_C = MAX_A > TOFF ? MAX_A : TOFF;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DT_LOAD = CW'(DEADTIME - 1);
  localparam logic [CW-1:0] BL_LOAD = CW'(BLANK - 1);
  localparam logic [CW-1:0] TF_LOAD = CW'(TOFF - 1);

  state_t        state, state_n;
  state_t        nxt, nxt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dir_q, dir_n;
  logic [3:0]    pat;
  logic          cnt_zero;

  assign cnt_zero = cnt == '0;
  assign {s_h1, s_l1, s_h2, s_l2} = pat;

  // State, shared counter and registered output decode of the upcoming state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= OFF;
      nxt          <= OFF;
      cnt          <= '0;
      dir_q        <= DIR_FWD;
      pat          <= PAT_OFF;
      drive_active <= 1'b0;
      decay_active <= 1'b0;
    end else begin
      state        <= state_n;
      nxt          <= nxt_n;
      cnt          <= cnt_n;
      dir_q        <= dir_n;
      pat          <= switch_pattern(state_n, dir_n);
      drive_active <= state_n == DRIVE;
      decay_active <= state_n == DECAY;
    end
  end

  // Next-state logic; every exit from DRIVE/DECAY passes through DEAD with a fresh dead-time count
  always_comb begin
    state_n = state;
    nxt_n   = nxt;
    cnt_n   = cnt_zero ? cnt : cnt - 1'b1;
    dir_n   = dir_q;
    case (state)
      OFF: begin
        cnt_n = '0;
        if (enable) begin
          state_n = DEAD;
          nxt_n   = DRIVE;
          cnt_n   = DT_LOAD;
        end
      end
      DEAD: begin
        if (!enable) nxt_n = OFF;
        if (cnt_zero) begin
          state_n = nxt_n;
          cnt_n   = nxt_n == DRIVE ? BL_LOAD : nxt_n == DECAY ? TF_LOAD : '0;
          if (nxt_n == DRIVE) dir_n = dir;
        end
      end
      DRIVE: begin
        if (!enable || dir != dir_q || (cnt_zero && current >= target)) begin
          state_n = DEAD;
          cnt_n   = DT_LOAD;
          nxt_n   = !enable ? OFF : dir != dir_q ? DRIVE : DECAY;
        end
      end
      DECAY: begin
        if (!enable || cnt_zero) begin
          state_n = DEAD;
          cnt_n   = DT_LOAD;
          nxt_n   = !enable ? OFF : DRIVE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_hbridge_chopper.sv
// tb_hbridge_chopper: directed self-checking bench with a linear coil model
module tb_hbridge_chopper;
  import hbridge_pkg::*;

  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          dir = 1'b0;
  logic [CW-1:0] target = '0;
  logic [CW-1:0] current = '0;
  logic          s_l1, s_h1, s_l2, s_h2, drive_active, decay_active;
  logic          model_on = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            off_run = 0;
  logic [3:0]    prev_pat = 4'b0000;

  hbridge_chopper #(.CURRENT_W(CW), .DEADTIME(4), .BLANK(8), .TOFF(32)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .dir(dir), .target(target), .current(current),
    .s_l1(s_l1), .s_h1(s_h1), .s_l2(s_l2), .s_h2(s_h2),
    .drive_active(drive_active), .decay_active(decay_active)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat();
    return {s_h1, s_l1, s_h2, s_l2};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; the coil model charges by one per driven cycle and collapses otherwise
  task automatic step();
    @(posedge clk);
    #1;
    if (model_on) current = ((s_h1 && s_l2) || (s_h2 && s_l1)) ? current + 1'b1 : '0;
  endtask

  // Starting on the first cycle of a segment, measure how long the pattern holds
  task automatic seg(input string tag, input logic [3:0] exp_pat, input int exp_len);
    int n;
    chk({tag, "_pat"}, int'(pat()), int'(exp_pat));
    n = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (pat() != exp_pat) break;
      n++;
    end
    chk({tag, "_len"}, n, exp_len);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    dir = DIR_FWD;
    model_on = 1'b0;
    current = '0;
    repeat (3) step();
    chk("rst_pat", int'(pat()), int'(PAT_OFF));
    chk("rst_act", int'({drive_active, decay_active}), 0);
    resetn = 1'b1;
  endtask

  task automatic hold_off(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, int'({pat(), drive_active, decay_active}), 0);
    end
  endtask

  // Shoot-through and dead-time guard, every cycle
  always @(negedge clk) begin
    chk("shoot", int'((s_h1 && s_l1) || (s_h2 && s_l2)), 0);
    if (pat() != 4'b0000 && prev_pat == 4'b0000) chk("deadtime", int'(off_run >= 4), 1);
    if (pat() != 4'b0000 && prev_pat != 4'b0000 && pat() != prev_pat) chk("direct", int'(pat()), int'(prev_pat));
    off_run = pat() == 4'b0000 ? off_run + 1 : 0;
    prev_pat = pat();
  end

  initial begin
    // 1: reset then enable; four dead cycles then forward drive
    do_reset();
    enable = 1'b1;
    target = 13'd100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_dead", int'({pat(), drive_active}), 0);
    end
    step();
    chk("t1_fwd", int'(pat()), int'(PAT_FWD));
    chk("t1_act", int'({drive_active, decay_active}), 2);

    // 2: closed-loop chop at 20
    do_reset();
    model_on = 1'b1;
    target = 13'd20;
    enable = 1'b1;
    step();
    seg("t2_dead0", PAT_OFF, 4);
    seg("t2_drv1", PAT_FWD, 20);
    seg("t2_dead1", PAT_OFF, 4);
    chk("t2_decay_act", int'({drive_active, decay_active}), 1);
    seg("t2_decay", PAT_BRAKE, 32);
    seg("t2_dead2", PAT_OFF, 4);
    seg("t2_drv2", PAT_FWD, 20);
    seg("t2_dead3", PAT_OFF, 4);

    // 3: target 0, drive limited by blanking
    do_reset();
    model_on = 1'b1;
    target = '0;
    enable = 1'b1;
    step();
    seg("t3_dead0", PAT_OFF, 4);
    seg("t3_drv1", PAT_FWD, 8);
    seg("t3_dead1", PAT_OFF, 4);
    seg("t3_decay", PAT_BRAKE, 32);
    seg("t3_dead2", PAT_OFF, 4);
    seg("t3_drv2", PAT_FWD, 8);

    // 4: reversal mid-DRIVE, then dir change during DECAY deferred
    do_reset();
    model_on = 1'b1;
    target = 13'd100;
    enable = 1'b1;
    step();
    seg("t4_dead0", PAT_OFF, 4);
    repeat (3) step();
    dir = DIR_REV;
    step();
    seg("t4_rev_dead", PAT_OFF, 4);
    target = '0;
    seg("t4_rev", PAT_REV, 8);
    seg("t4_dead1", PAT_OFF, 4);
    dir = DIR_FWD;
    seg("t4_decay", PAT_BRAKE, 32);
    seg("t4_dead2", PAT_OFF, 4);
    chk("t4_fwd", int'(pat()), int'(PAT_FWD));

    // 5a: disable during DRIVE together with a dir change; enable wins
    do_reset();
    target = 13'd100;
    enable = 1'b1;
    step();
    seg("t5a_dead0", PAT_OFF, 4);
    step();
    enable = 1'b0;
    dir = DIR_REV;
    hold_off("t5a_off", 8);
    enable = 1'b1;
    dir = DIR_FWD;
    step();
    seg("t5a_restart", PAT_OFF, 4);
    chk("t5a_fwd", int'(pat()), int'(PAT_FWD));

    // 5b: disable during DECAY
    do_reset();
    target = '0;
    enable = 1'b1;
    step();
    seg("t5b_dead0", PAT_OFF, 4);
    seg("t5b_drv", PAT_FWD, 8);
    seg("t5b_dead1", PAT_OFF, 4);
    repeat (3) step();
    chk("t5b_decay", int'(pat()), int'(PAT_BRAKE));
    enable = 1'b0;
    hold_off("t5b_off", 8);

    // 5c: disable during the initial DEAD that was heading to DRIVE
    do_reset();
    target = 13'd100;
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    hold_off("t5c_off", 8);

    // 6: reset mid-DRIVE, then restart from OFF
    do_reset();
    target = 13'd100;
    enable = 1'b1;
    step();
    seg("t6_dead0", PAT_OFF, 4);
    repeat (3) step();
    resetn = 1'b0;
    step();
    chk("t6_rst", int'({pat(), drive_active, decay_active}), 0);
    resetn = 1'b1;
    seg("t6_restart", PAT_OFF, 5);
    chk("t6_fwd", int'(pat()), int'(PAT_FWD));

    // Boundary: all-ones target with saturated current still chops after blanking
    do_reset();
    target = '1;
    current = '1;
    enable = 1'b1;
    step();
    seg("max_dead0", PAT_OFF, 4);
    seg("max_drv", PAT_FWD, 8);
    seg("max_dead1", PAT_OFF, 4);
    chk("max_decay", int'(pat()), int'(PAT_BRAKE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
